rob_retire: RTL and testbench

In-order reorder buffer and retire unit that drives the commit side of the architectural rename tables. It accepts one renamed uop per cycle from rename and records destination arch register, new physical register and previous physical register. It accepts out-of-order completion from execute and retires the oldest completed uop each cycle. On retire it updates the non-speculative map and returns the freed physical register. On a mispredicted retire it pulses `rollback` and walks back the squashed entries so their physical registers return to the free list.

---
 rtl/rob_retire_pkg.sv | 30 +++
 rtl/rob_entry_array.sv | 70 +++++++
 rtl/rob_retire.sv | 146 ++++++++++++++
 tb/tb_rob_retire.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_retire_pkg.sv
// Shared widths, FSM states and entry flags
// for the reorder buffer / retire unit.
package rob_retire_pkg;

  function automatic int a_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int p_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int t_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    RB   = 2'd1,
    WALK = 2'd2
  } rob_state_e;

  typedef struct packed {
    logic valid;
    logic done;
    logic mispred;
    logic has_rd;
  } rob_flags_t;

endpackage

// File: rtl/rob_entry_array.sv
// ROB entry storage: alloc write, completion set,
// head read, tail-1 read and a single clear port.
module rob_entry_array
  import rob_retire_pkg::*;
#(
  parameter int N = 32,
  parameter int A = 5,
  parameter int P = 8,
  parameter int T = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [T-1:0] wr_idx,
  input  logic         wr_has_rd,
  input  logic [A-1:0] wr_arch,
  input  logic [P-1:0] wr_phys,
  input  logic [P-1:0] wr_oldphys,
  input  logic         set_en,
  input  logic [T-1:0] set_idx,
  input  logic         set_mispred,
  input  logic [T-1:0] hd_idx,
  output rob_flags_t   hd_flags,
  output logic [A-1:0] hd_arch,
  output logic [P-1:0] hd_phys,
  output logic [P-1:0] hd_oldphys,
  input  logic [T-1:0] tl_idx,
  output logic         tl_has_rd,
  output logic [P-1:0] tl_phys,
  input  logic         clr_en,
  input  logic [T-1:0] clr_idx
);

  rob_flags_t   flags   [N];
  logic [A-1:0] arch_q  [N];
  logic [P-1:0] phys_q  [N];
  logic [P-1:0] old_q   [N];

  // Flags: clear beats a late completion on the same slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) flags[i] <= '0;
    end else begin
      if (set_en && flags[set_idx].valid) begin
        flags[set_idx].done    <= 1'b1;
        flags[set_idx].mispred <= set_mispred;
      end
      if (clr_en) flags[clr_idx] <= '0;
      if (wr_en)
        flags[wr_idx] <= '{1'b1, 1'b0, 1'b0, wr_has_rd};
    end
  end

  // Payload is only meaningful while the valid flag is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      arch_q[wr_idx] <= wr_arch;
      phys_q[wr_idx] <= wr_phys;
      old_q[wr_idx]  <= wr_oldphys;
    end
  end

  assign hd_flags   = flags[hd_idx];
  assign hd_arch    = arch_q[hd_idx];
  assign hd_phys    = phys_q[hd_idx];
  assign hd_oldphys = old_q[hd_idx];
  assign tl_has_rd  = flags[tl_idx].has_rd;
  assign tl_phys    = phys_q[tl_idx];

endmodule

// File: rtl/rob_retire.sv
// In-order ROB: allocate, out-of-order completion,
// in-order retire and post-mispredict walk-back.
module rob_retire
  import rob_retire_pkg::*;
#(
  parameter int ARCHFILE_SIZE = 32,
  parameter int PHYSFILE_SIZE = 256,
  parameter int ROB_SIZE      = 32,
  localparam int A = a_width(ARCHFILE_SIZE),
  localparam int P = p_width(PHYSFILE_SIZE),
  localparam int T = t_width(ROB_SIZE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alloc_valid,
  output logic         alloc_ready,
  input  logic         alloc_has_rd,
  input  logic [A-1:0] alloc_arch_wr,
  input  logic [P-1:0] alloc_phys,
  input  logic [P-1:0] alloc_oldphys,
  output logic [T-1:0] alloc_tag,
  input  logic         cmpl_valid,
  input  logic [T-1:0] cmpl_tag,
  input  logic         cmpl_mispredict,
  output logic         rob_update,
  output logic [A-1:0] arch_rob_update,
  output logic [P-1:0] arch_rob_nonspec_phys,
  output logic         rollback,
  output logic         free_valid,
  output logic [P-1:0] free_phys,
  output logic         rob_empty,
  output logic [T:0]   rob_count
);

  rob_state_e   state, state_nx;
  logic [T:0]   head, tail, tail_m1, count;
  logic         full, retire, walk_go;
  logic         alloc_fire, set_en, clr_en;
  logic [T-1:0] clr_idx;
  rob_flags_t   hd_flags;
  logic [A-1:0] hd_arch;
  logic [P-1:0] hd_phys, hd_oldphys, tl_phys;
  logic         tl_has_rd;

  assign count     = tail - head;
  assign tail_m1   = tail - (T+1)'(1);
  assign full      = (count == (T+1)'(ROB_SIZE));
  assign rob_count = count;
  assign rob_empty = (count == '0);
  assign alloc_tag = tail[T-1:0];

  rob_entry_array #(
    .N(ROB_SIZE), .A(A), .P(P), .T(T)
  ) u_arr (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (alloc_fire),
    .wr_idx      (tail[T-1:0]),
    .wr_has_rd   (alloc_has_rd),
    .wr_arch     (alloc_arch_wr),
    .wr_phys     (alloc_phys),
    .wr_oldphys  (alloc_oldphys),
    .set_en      (set_en),
    .set_idx     (cmpl_tag),
    .set_mispred (cmpl_mispredict),
    .hd_idx      (head[T-1:0]),
    .hd_flags    (hd_flags),
    .hd_arch     (hd_arch),
    .hd_phys     (hd_phys),
    .hd_oldphys  (hd_oldphys),
    .tl_idx      (tail_m1[T-1:0]),
    .tl_has_rd   (tl_has_rd),
    .tl_phys     (tl_phys),
    .clr_en      (clr_en),
    .clr_idx     (clr_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nx;
  end

  // Next state: a walk ends on its last squashed entry.
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:  if (retire && hd_flags.mispred) state_nx = RB;
      RB:   state_nx = WALK;
      WALK: if (tail == head || tail_m1 == head)
              state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // Per-state control decode.
  always_comb begin
    alloc_ready = 1'b0;
    retire      = 1'b0;
    walk_go     = 1'b0;
    set_en      = 1'b0;
    if (state == RUN) begin
      alloc_ready = !full;
      retire      = hd_flags.valid & hd_flags.done;
      set_en      = cmpl_valid;
    end
    if (state == WALK) walk_go = (tail != head);
    alloc_fire = alloc_valid & alloc_ready;
    clr_en     = retire | walk_go;
    clr_idx    = retire ? head[T-1:0] : tail_m1[T-1:0];
  end

  // Head advances on retire; tail on alloc or walk-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (retire) head <= head + (T+1)'(1);
      if (walk_go)         tail <= tail_m1;
      else if (alloc_fire) tail <= tail + (T+1)'(1);
    end
  end

  // Registered commit, rollback and free strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rob_update            <= 1'b0;
      arch_rob_update       <= '0;
      arch_rob_nonspec_phys <= '0;
      rollback              <= 1'b0;
      free_valid            <= 1'b0;
      free_phys             <= '0;
    end else begin
      rob_update            <= retire & hd_flags.has_rd;
      arch_rob_update       <= retire ? hd_arch : '0;
      arch_rob_nonspec_phys <= retire ? hd_phys : '0;
      rollback              <= (state == RB);
      free_valid            <= (retire & hd_flags.has_rd)
                             | (walk_go & tl_has_rd);
      free_phys             <= retire  ? hd_oldphys :
                               walk_go ? tl_phys    : '0;
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire with a queue-based
// reference model checked every cycle.
module tb_rob_retire;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_valid = 0, alloc_has_rd = 0;
  logic [4:0] alloc_arch_wr = 0;
  logic [7:0] alloc_phys = 0, alloc_oldphys = 0;
  logic       alloc_ready;
  logic [4:0] alloc_tag;
  logic       cmpl_valid = 0, cmpl_mispredict = 0;
  logic [4:0] cmpl_tag = 0;
  logic       rob_update, rollback, free_valid, rob_empty;
  logic [4:0] arch_rob_update;
  logic [7:0] arch_rob_nonspec_phys, free_phys;
  logic [5:0] rob_count;

  int n_chk = 0;
  int n_err = 0;

  rob_retire dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_has_rd(alloc_has_rd),
    .alloc_arch_wr(alloc_arch_wr),
    .alloc_phys(alloc_phys), .alloc_oldphys(alloc_oldphys),
    .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
    .cmpl_mispredict(cmpl_mispredict),
    .rob_update(rob_update),
    .arch_rob_update(arch_rob_update),
    .arch_rob_nonspec_phys(arch_rob_nonspec_phys),
    .rollback(rollback),
    .free_valid(free_valid), .free_phys(free_phys),
    .rob_empty(rob_empty), .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int tag; bit has_rd; int arch; int phys; int old;
    bit done; bit mis;
  } ment_t;

  ment_t q[$];
  int m_mode = 0;   // 0 run, 1 rollback cycle, 2 walk
  int m_tail = 0;
  bit e_upd = 0, e_rb = 0, e_fv = 0;
  int e_arch = 0, e_phys = 0, e_fp = 0;

  initial begin
    ment_t h;
    bit rdy;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        m_mode = 0; m_tail = 0;
        e_upd = 0; e_rb = 0; e_fv = 0;
        e_arch = 0; e_phys = 0; e_fp = 0;
      end else begin
        e_upd = 0; e_rb = 0; e_fv = 0;
        case (m_mode)
          0: begin
            rdy = (q.size() < 32);
            if (q.size() > 0 && q[0].done) begin
              h = q.pop_front();
              e_upd = h.has_rd; e_arch = h.arch;
              e_phys = h.phys;
              e_fv = h.has_rd; e_fp = h.old;
              if (h.mis) m_mode = 1;
            end
            if (cmpl_valid)
              foreach (q[k])
                if (q[k].tag == int'(cmpl_tag)) begin
                  q[k].done = 1;
                  q[k].mis = cmpl_mispredict;
                end
            if (alloc_valid && rdy) begin
              h.tag = m_tail; h.has_rd = alloc_has_rd;
              h.arch = alloc_arch_wr;
              h.phys = alloc_phys; h.old = alloc_oldphys;
              h.done = 0; h.mis = 0;
              q.push_back(h);
              m_tail = (m_tail + 1) % 32;
            end
          end
          1: begin
            e_rb = 1;
            m_mode = 2;
          end
          default: begin
            if (q.size() > 0) begin
              h = q.pop_back();
              e_fv = h.has_rd; e_fp = h.phys;
              m_tail = (m_tail + 31) % 32;
            end
            if (q.size() == 0) m_mode = 0;
          end
        endcase
      end
    end
  end

  // ---------------- compare + observation logs ----------------
  int cyc_n = 0;
  int upd_arch[$], upd_phys[$], upd_cyc[$];
  int free_log[$], free_cyc[$];
  int rb_cnt = 0, rb_cyc = -1, ready_cyc = -1;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc_n++;
      chk("alloc_ready", alloc_ready,
          (m_mode == 0 && q.size() < 32));
      chk("rob_count", rob_count, q.size());
      chk("rob_empty", rob_empty, q.size() == 0);
      chk("alloc_tag", alloc_tag, m_tail);
      chk("rob_update", rob_update, e_upd);
      chk("rollback", rollback, e_rb);
      chk("free_valid", free_valid, e_fv);
      if (e_upd) begin
        chk("arch_rob_update", arch_rob_update, e_arch);
        chk("nonspec_phys", arch_rob_nonspec_phys, e_phys);
      end
      if (e_fv) chk("free_phys", free_phys, e_fp);
      if (rst) begin
        if (rob_update) begin
          upd_arch.push_back(arch_rob_update);
          upd_phys.push_back(arch_rob_nonspec_phys);
          upd_cyc.push_back(cyc_n);
        end
        if (free_valid) begin
          free_log.push_back(free_phys);
          free_cyc.push_back(cyc_n);
        end
        if (rollback) begin
          rb_cnt++;
          rb_cyc = cyc_n;
        end
        if (alloc_ready && rb_cyc >= 0 &&
            ready_cyc < 0 && cyc_n > rb_cyc)
          ready_cyc = cyc_n;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit av, input bit hr,
                     input int ar, input int ph,
                     input int op, input bit cv,
                     input int ct, input bit cm);
    @(negedge clk);
    alloc_valid = av; alloc_has_rd = hr;
    alloc_arch_wr = 5'(ar);
    alloc_phys = 8'(ph); alloc_oldphys = 8'(op);
    cmpl_valid = cv; cmpl_tag = 5'(ct);
    cmpl_mispredict = cm;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_logs();
    upd_arch.delete(); upd_phys.delete(); upd_cyc.delete();
    free_log.delete(); free_cyc.delete();
    rb_cnt = 0; rb_cyc = -1; ready_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    alloc_valid = 0; alloc_has_rd = 0; cmpl_valid = 0;
    cmpl_mispredict = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_empty", rob_empty, 1);
    chk("rst_count", rob_count, 0);
    chk("rst_update", rob_update, 0);
    chk("rst_free", free_valid, 0);
    #2;
    rst = 1'b1;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int bad;
    bit seen;

    // basic in-order retire of out-of-order completions
    do_reset();
    cyc(1, 1, 5, 40, 7, 0, 0, 0);
    cyc(1, 1, 6, 41, 8, 0, 0, 0);
    cyc(1, 0, 9, 42, 9, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 9, 0);
    cyc(0, 0, 0, 0, 0, 1, 2, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    idle(6);
    chk("s1_upd_n", upd_arch.size(), 2);
    if (upd_arch.size() == 2) begin
      chk("s1_upd0_arch", upd_arch[0], 5);
      chk("s1_upd0_phys", upd_phys[0], 40);
      chk("s1_upd1_arch", upd_arch[1], 6);
      chk("s1_upd1_phys", upd_phys[1], 41);
    end
    chk("s1_free_n", free_log.size(), 2);
    if (free_log.size() == 2) begin
      chk("s1_free0", free_log[0], 7);
      chk("s1_free1", free_log[1], 8);
    end
    chk("s1_empty", rob_empty, 1);

    // fill to full, retire one
    do_reset();
    for (int i = 0; i < 33; i++)
      cyc(1, 1, i % 32, i, i + 100, 0, 0, 0);
    idle(1);
    chk("s2_full_ready", alloc_ready, 0);
    chk("s2_full_count", rob_count, 32);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    @(negedge clk);
    chk("s2_after_ready", alloc_ready, 1);
    chk("s2_after_count", rob_count, 31);

    // mispredict, rollback and walk
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(1, 1, i + 1, 50 + i, 60 + i, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    idle(10);
    chk("s3_rb_n", rb_cnt, 1);
    chk("s3_upd_n", upd_arch.size(), 2);
    chk("s3_free_n", free_log.size(), 4);
    if (free_log.size() == 4 && upd_cyc.size() == 2) begin
      chk("s3_free0", free_log[0], 60);
      chk("s3_free1", free_log[1], 61);
      chk("s3_free2", free_log[2], 53);
      chk("s3_free3", free_log[3], 52);
      chk("s3_upd_before_rb", upd_cyc[1], rb_cyc - 1);
      chk("s3_walk_f0_cyc", free_cyc[2], rb_cyc + 1);
      chk("s3_walk_f1_cyc", free_cyc[3], rb_cyc + 2);
    end
    chk("s3_ready_cyc", ready_cyc, rb_cyc + 2);
    chk("s3_empty", rob_empty, 1);

    // 70-uop stream with tag wrap
    do_reset();
    for (int i = 0; i < 70; i++) begin
      cyc(1, 1, i % 32, (i + 1) % 256, (i + 128) % 256,
          i > 0, (i + 31) % 32, 0);
      if (i == 32) chk("s4_tag_wrap", alloc_tag, 0);
    end
    cyc(0, 0, 0, 0, 0, 1, 69 % 32, 0);
    idle(6);
    chk("s4_upd_n", upd_phys.size(), 70);
    bad = 0;
    for (int k = 0; k < upd_phys.size(); k++)
      if (upd_phys[k] != k + 1 || upd_arch[k] != k % 32 ||
          k >= free_log.size() || free_log[k] != k + 128)
        bad++;
    chk("s4_order", bad, 0);
    chk("s4_empty", rob_empty, 1);

    // reset in the middle of a walk
    do_reset();
    for (int i = 0; i < 6; i++)
      cyc(1, 1, 10 + i, 70 + i, 90 + i, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 1);
    idle(1);
    seen = 0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      if (rollback) seen = 1;
    end
    chk("s5_rb_seen", seen, 1);
    free_log.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("s5_rst_count", rob_count, 0);
    chk("s5_rst_free", free_valid, 0);
    #2;
    rst = 1'b1;
    idle(6);
    chk("s5_free_n", free_log.size(), 1);
    if (free_log.size() == 1)
      chk("s5_free0", free_log[0], 75);
    chk("s5_empty", rob_empty, 1);
    chk("s5_ready", alloc_ready, 1);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
